vga_timing: RTL and testbench

// - Source end of the vga_if bus: generates hcount/vcount, hsync/vsync, hblnk/vblnk for
//   800x600@60 (40 MHz pixel clock) and drives rgb = 0; all drawing stages consume it downstream.
// - Adds pixel-enable gating, start-of-frame pulse and a frame counter for animated levels.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_if.sv | 16 +
 rtl/vga_timing_wrap_counter.sv | 43 ++++
 rtl/vga_timing.sv | 94 +++++++++
 tb/tb_vga_timing.sv | 136 +++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600@60, 40 MHz pixel clock) and helpers.
package vga_pkg;

  localparam int CNT_W     = 11;
  localparam int CNT_LIMIT = 2048;

  localparam int HOR_PIXELS = 800;
  localparam int H_FP       = 40;
  localparam int H_SYNC     = 128;
  localparam int H_BP       = 88;
  localparam int H_TOTAL    = HOR_PIXELS + H_FP + H_SYNC + H_BP;

  localparam int VER_PIXELS = 600;
  localparam int V_FP       = 1;
  localparam int V_SYNC     = 4;
  localparam int V_BP       = 23;
  localparam int V_TOTAL    = VER_PIXELS + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] RGB_BLANK = 12'h000;

  typedef struct packed {
    logic hsync;
    logic hblnk;
    logic vsync;
    logic vblnk;
  } vga_flags_t;

  // True when lo <= val < lo+len.
  function automatic logic in_window(input int val, input int lo, input int len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA bus between the timing source and the drawing stages.
interface vga_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] vcount;
  logic             vsync;
  logic             vblnk;
  logic [CNT_W-1:0] hcount;
  logic             hsync;
  logic             hblnk;
  logic [11:0]      rgb;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/vga_timing_wrap_counter.sv
// Counter 0..MAX that advances on inc and wraps to 0. Exposes its next value
// so the parent can decode flags that line up with the registered count.
module wrap_counter #(
  parameter int W   = 11,
  parameter int MAX = 1055
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count and wrap strobe; wrap only fires when the counter actually advances.
  always_comb begin
    count_d = count_q;
    wrap_o  = 1'b0;
    if (inc) begin
      if (count_q == MAX_V) begin
        count_d = '0;
        wrap_o  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/vga_timing.sv
// VGA timing source: pixel/line counters, sync and blank flags, start-of-frame
// pulse and frame counter. All outputs are registered and aligned to the counters.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::HOR_PIXELS,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::VER_PIXELS,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit SYNC_POL = 1'b1,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  vga_if.out                vga_out,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > CNT_LIMIT || V_TOT > CNT_LIMIT) begin : g_bad_timing
    $fatal(1, "vga_timing: line or frame total exceeds 11-bit counter range");
  end

  logic [CNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
  logic             h_wrap, v_wrap;

  wrap_counter #(.W(CNT_W), .MAX(H_TOT - 1)) u_hcnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (ce),
    .count_o (h_cnt),
    .next_o  (h_nxt),
    .wrap_o  (h_wrap)
  );

  wrap_counter #(.W(CNT_W), .MAX(V_TOT - 1)) u_vcnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (ce & h_wrap),
    .count_o (v_cnt),
    .next_o  (v_nxt),
    .wrap_o  (v_wrap)
  );

  vga_flags_t       flags_q, flags_d, flags_idle;
  logic             frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign flags_idle = '{hsync: ~SYNC_POL, hblnk: 1'b0, vsync: ~SYNC_POL, vblnk: 1'b0};

  // Decode flags from the next counter values so they land with the counters.
  // The v counter only moves on an h wrap with ce, so its wrap marks (0,0).
  always_comb begin
    flags_d       = flags_idle;
    flags_d.hblnk = (int'(h_nxt) >= H_ACTIVE);
    flags_d.vblnk = (int'(v_nxt) >= V_ACTIVE);
    flags_d.hsync = in_window(int'(h_nxt), H_ACTIVE + H_FP, H_SYNC) ~^ SYNC_POL;
    flags_d.vsync = in_window(int'(v_nxt), V_ACTIVE + V_FP, V_SYNC) ~^ SYNC_POL;
    frame_start_d = v_wrap;
    frame_cnt_d   = frame_cnt_q + FCNT_W'(v_wrap);
  end

  // Flag, pulse and frame counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q       <= flags_idle;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      flags_q       <= flags_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga_out.hcount = h_cnt;
  assign vga_out.vcount = v_cnt;
  assign vga_out.hsync  = flags_q.hsync;
  assign vga_out.hblnk  = flags_q.hblnk;
  assign vga_out.vsync  = flags_q.vsync;
  assign vga_out.vblnk  = flags_q.vblnk;
  assign vga_out.rgb    = RGB_BLANK;
  assign frame_start    = frame_start_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: shrunken timing, two builds (active-high and active-low
// sync), reference model works on a linear pixel index within the frame.
module tb_vga_timing;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 10, VFP = 1, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;   // 25
  localparam int VT = VA + VFP + VS + VBP;   // 16
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  logic              fs0, fs1;
  logic [FW-1:0]     fc0, fc1;

  vga_if vif0 ();
  vga_if vif1 ();

  vga_timing #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
               .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
               .SYNC_POL(1'b1), .FCNT_W(FW)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .vga_out(vif0), .frame_start(fs0), .frame_cnt(fc0));

  vga_timing #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
               .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
               .SYNC_POL(1'b0), .FCNT_W(FW)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .vga_out(vif1), .frame_start(fs1), .frame_cnt(fc1));

  always #5 clk = ~clk;

  typedef struct {
    int h, v, fc;
    bit hs, hb, vs, vb, fs;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference: pixel index inside the frame, frames completed, pulse.
  int m_pix = 0;
  int m_fc  = 0;
  bit m_fs  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit c, input bit r);
    exp_t e;
    if (r) begin
      m_pix = 0; m_fc = 0; m_fs = 1'b0;
    end else if (c) begin
      m_pix = (m_pix + 1) % (HT * VT);
      m_fs  = (m_pix == 0);
      if (m_fs) m_fc = (m_fc + 1) % (1 << FW);
    end else begin
      m_fs = 1'b0;
    end
    e.h  = m_pix % HT;
    e.v  = m_pix / HT;
    e.hb = (e.h >= HA);
    e.vb = (e.v >= VA);
    e.hs = (e.h >= HA + HFP) && (e.h < HA + HFP + HS);
    e.vs = (e.v >= VA + VFP) && (e.v < VA + VFP + VS);
    e.fs = m_fs;
    e.fc = m_fc;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit c, input bit r);
    ce  = c;
    rst = r;
    @(posedge clk);
    model_edge(c, r);
    #1;
  endtask

  // Monitor: every clock presents a new output word; compare it away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("hcount",      int'(vif0.hcount), e.h);
      check("vcount",      int'(vif0.vcount), e.v);
      check("hsync",       int'(vif0.hsync),  int'(e.hs));
      check("hblnk",       int'(vif0.hblnk),  int'(e.hb));
      check("vsync",       int'(vif0.vsync),  int'(e.vs));
      check("vblnk",       int'(vif0.vblnk),  int'(e.vb));
      check("rgb",         int'(vif0.rgb),    0);
      check("frame_start", int'(fs0),         int'(e.fs));
      check("frame_cnt",   int'(fc0),         e.fc);
      check("lo_hcount",   int'(vif1.hcount), e.h);
      check("lo_vcount",   int'(vif1.vcount), e.v);
      check("lo_hsync",    int'(vif1.hsync),  int'(!e.hs));
      check("lo_vsync",    int'(vif1.vsync),  int'(!e.vs));
      check("lo_blank",    int'({vif1.hblnk, vif1.vblnk}), int'({e.hb, e.vb}));
      check("lo_frame",    int'({fs1, fc1}),  int'({e.fs, 2'(e.fc)}));
    end
  end

  initial begin
    bit hit;
    // reset, held a few cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    // free-run past one full wrap of the 2-bit frame counter
    for (int i = 0; i < 4 * HT * VT + HT * VT / 2; i++) step(1'b1, 1'b0);
    // random pixel enable
    for (int i = 0; i < 3 * HT * VT; i++) step(($urandom_range(0, 9) < 7), 1'b0);
    // reach frame_cnt=3 mid-frame, then reset
    hit = 1'b0;
    for (int i = 0; i < 8 * HT * VT && !hit; i++) begin
      if (m_fc == 3 && m_pix == (VT / 2) * HT + HT / 2) hit = 1'b1;
      else step(1'b1, 1'b0);
    end
    check("reach_mid_frame3", int'(hit), 1);
    step(1'b1, 1'b1);
    // ce pattern 1,0,0,1 across line and frame boundaries
    for (int i = 0; i < 2 * HT * VT; i++) step((i % 4 == 0) || (i % 4 == 3), 1'b0);
    // random ce with rare resets
    for (int i = 0; i < 4 * HT * VT; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
    ce  = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
